// File: rtl/packet_framer_pkg.sv
// Shared types and constants for the transmit-side packet framer.
// Frame: SOF, CMD_HI, CMD_LO, LEN2..LEN0, payload, CHK, EOF.
package packet_framer_pkg;

    localparam int LEN_WIDTH = 24;
    localparam int CHK_WIDTH = 8;
    localparam logic [7:0] SOF_DEFAULT = 8'hA5;
    localparam logic [7:0] EOF_DEFAULT = 8'h5A;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SOF,
        ST_CMD_HI,
        ST_CMD_LO,
        ST_LEN2,
        ST_LEN1,
        ST_LEN0,
        ST_PAYLOAD,
        ST_CHK,
        ST_EOF
    } state_e;

    function automatic state_e next_state(input state_e s);
        state_e n;
        unique case (s)
            ST_SOF:     n = ST_CMD_HI;
            ST_CMD_HI:  n = ST_CMD_LO;
            ST_CMD_LO:  n = ST_LEN2;
            ST_LEN2:    n = ST_LEN1;
            ST_LEN1:    n = ST_LEN0;
            ST_LEN0:    n = ST_PAYLOAD;
            ST_CHK:     n = ST_EOF;
            default:    n = ST_IDLE;
        endcase
        return n;
    endfunction

    // SOF, CHK and EOF stay out of the running sum
    function automatic logic in_checksum(input state_e s);
        return (s != ST_IDLE) && (s != ST_SOF) &&
               (s != ST_CHK) && (s != ST_EOF);
    endfunction

endpackage

// File: rtl/framer_byte_sender.sv
// UART byte pacing: one strobe when the transmitter is ready,
// followed by a guard cycle that ignores UART ready.
module framer_byte_sender (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_req_i,
    input  logic [7:0] send_byte_i,
    input  logic       uart_ready_i,
    output logic [7:0] uart_data_o,
    output logic       uart_is_new_o,
    output logic       send_ack_o,
    output logic       guard_o
);

    logic guard_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            guard_q <= 1'b0;
        end else begin
            guard_q <= send_ack_o;
        end
    end

    assign send_ack_o    = send_req_i && uart_ready_i && !guard_q;
    assign uart_is_new_o = send_ack_o;
    assign uart_data_o   = send_ack_o ? send_byte_i : 8'h00;
    assign guard_o       = guard_q;

endmodule

// File: rtl/packet_framer.sv
// Wraps a pixel stream into a framed, checksummed packet
// and paces the bytes into the UART transmitter.
import packet_framer_pkg::*;

module packet_framer #(
    parameter int         COMMAND_WIDTH = 16,
    parameter int         PIXEL_WIDTH   = 8,
    parameter int         FRAME_BYTES   = 76800,
    parameter logic [7:0] SOF_BYTE      = SOF_DEFAULT,
    parameter logic [7:0] EOF_BYTE      = EOF_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [COMMAND_WIDTH-1:0] command,
    input  logic                     stop,
    input  logic [PIXEL_WIDTH-1:0]   pixel_data,
    input  logic                     pixel_valid,
    output logic                     pixel_ready,
    input  logic                     UART_ready,
    output logic [7:0]               UART_data,
    output logic                     UART_is_new,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted
);

    localparam logic [LEN_WIDTH-1:0] LEN = LEN_WIDTH'(FRAME_BYTES);

    state_e                   state_q, state_d;
    logic [COMMAND_WIDTH-1:0] cmd_q, cmd_d;
    logic [LEN_WIDTH-1:0]     cnt_q, cnt_d;
    logic [CHK_WIDTH-1:0]     chk_q, chk_d;
    logic [PIXEL_WIDTH-1:0]   hold_q, hold_d;
    logic                     hold_vld_q, hold_vld_d;
    logic                     done_q, done_d;
    logic                     abort_q, abort_d;
    logic                     send_req, send_ack, guard;
    logic [7:0]               send_byte;

    framer_byte_sender u_sender (
        .clk          (clk),
        .rst          (rst),
        .send_req_i   (send_req),
        .send_byte_i  (send_byte),
        .uart_ready_i (UART_ready),
        .uart_data_o  (UART_data),
        .uart_is_new_o(UART_is_new),
        .send_ack_o   (send_ack),
        .guard_o      (guard)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            cnt_q      <= '0;
            chk_q      <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            cnt_q      <= cnt_d;
            chk_q      <= chk_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    always_comb begin
        send_req    = 1'b1;
        send_byte   = 8'h00;
        pixel_ready = 1'b0;
        unique case (state_q)
            ST_SOF:    send_byte = SOF_BYTE;
            ST_CMD_HI: send_byte = cmd_q[COMMAND_WIDTH-1 -: 8];
            ST_CMD_LO: send_byte = cmd_q[7:0];
            ST_LEN2:   send_byte = LEN[23:16];
            ST_LEN1:   send_byte = LEN[15:8];
            ST_LEN0:   send_byte = LEN[7:0];
            ST_PAYLOAD: begin
                send_req    = hold_vld_q;
                send_byte   = hold_q;
                pixel_ready = !hold_vld_q && (cnt_q < LEN);
            end
            ST_CHK:    send_byte = chk_q;
            ST_EOF:    send_byte = EOF_BYTE;
            default:   send_req = 1'b0;
        endcase
        if (stop) begin
            send_req    = 1'b0;
            pixel_ready = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        cnt_d      = cnt_q;
        chk_d      = chk_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        if (state_q == ST_IDLE) begin
            if (start && !stop) begin
                cmd_d      = command;
                cnt_d      = '0;
                chk_d      = '0;
                hold_vld_d = 1'b0;
                state_d    = ST_SOF;
            end
        end else if (stop) begin
            // let a pending guard cycle expire before leaving
            if (!guard) begin
                state_d    = ST_IDLE;
                abort_d    = 1'b1;
                hold_vld_d = 1'b0;
            end
        end else begin
            if (pixel_valid && pixel_ready) begin
                hold_d     = pixel_data;
                hold_vld_d = 1'b1;
            end
            if (send_ack) begin
                if (in_checksum(state_q)) begin
                    chk_d = chk_q + send_byte;
                end
                unique case (1'b1)
                    (state_q == ST_PAYLOAD): begin
                        hold_vld_d = 1'b0;
                        cnt_d      = cnt_q + 1'b1;
                        if (cnt_d == LEN) begin
                            state_d = ST_CHK;
                        end
                    end
                    (state_q == ST_EOF): begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                    default: state_d = next_state(state_q);
                endcase
            end
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign aborted = abort_q;

endmodule
